// File: rtl/seg7_pkg.sv
// Shared 7-segment constants for the BCD display path.
// Segment words are ordered {a,b,c,d,e,f,g} and are active-low (0 = lit).
package seg7_pkg;

  localparam int unsigned SEG_W = 7;
  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_bcd_digit.sv
// Combinational BCD-to-7-segment decoder for one digit, with a blank override.
module seg7_bcd_digit
  import seg7_pkg::*;
(
  input  logic [3:0]       i_bcd,
  input  logic             i_blank,
  output logic [SEG_W-1:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      case (i_bcd)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_counter_display.sv
// N-digit BCD up/down counter with prescaler, load/clear, terminal-count pulse
// and a registered 7-segment decode per digit (optional leading-zero blanking).
module bcd_counter_display
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned PRESCALE   = 1,
  parameter int unsigned BLANK_LZ   = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic                        up_dn,
  input  logic                        clear,
  input  logic                        load,
  input  logic [4*NUM_DIGITS-1:0]     load_val,
  output logic [4*NUM_DIGITS-1:0]     count,
  output logic [SEG_W*NUM_DIGITS-1:0] hex,
  output logic                        tc,
  output logic                        load_err
);

  localparam int unsigned PresW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PresW-1:0] PresLast = PresW'(PRESCALE - 1);

  function automatic logic [SEG_W*NUM_DIGITS-1:0] hex_reset_word();
    logic [SEG_W*NUM_DIGITS-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      v[SEG_W*k +: SEG_W] = ((k == 0) || (BLANK_LZ == 0)) ? SEG_0 : SEG_BLANK;
    end
    return v;
  endfunction

  localparam logic [SEG_W*NUM_DIGITS-1:0] HexRst = hex_reset_word();

  logic [PresW-1:0]              r_presc;
  logic [4*NUM_DIGITS-1:0]       r_count;
  logic [SEG_W*NUM_DIGITS-1:0]   r_hex;
  logic                          r_tc;
  logic                          r_load_err;

  logic                          w_tick;
  logic [PresW-1:0]              w_presc_d;
  logic [4*NUM_DIGITS-1:0]       w_cnt_up;
  logic [4*NUM_DIGITS-1:0]       w_cnt_dn;
  logic                          w_carry;
  logic                          w_borrow;
  logic [4*NUM_DIGITS-1:0]       w_load_fix;
  logic                          w_load_bad;
  logic [NUM_DIGITS-1:0]         w_blank;
  logic                          w_zero_run;
  logic [SEG_W*NUM_DIGITS-1:0]   w_hex;

  assign w_tick = en && (r_presc == PresLast);

  always_comb begin
    w_presc_d = r_presc;
    if (clear || load) begin
      w_presc_d = '0;
    end else if (en) begin
      w_presc_d = w_tick ? '0 : r_presc + 1'b1;
    end
  end

  // Single-cycle ripple; carry/borrow left set means every digit wrapped.
  always_comb begin
    w_cnt_up = r_count;
    w_cnt_dn = r_count;
    w_carry  = 1'b1;
    w_borrow = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w_carry) begin
        if (r_count[4*k +: 4] >= BCD_MAX) begin
          w_cnt_up[4*k +: 4] = 4'd0;
        end else begin
          w_cnt_up[4*k +: 4] = r_count[4*k +: 4] + 4'd1;
          w_carry = 1'b0;
        end
      end
      if (w_borrow) begin
        if (r_count[4*k +: 4] == 4'd0) begin
          w_cnt_dn[4*k +: 4] = BCD_MAX;
        end else begin
          w_cnt_dn[4*k +: 4] = r_count[4*k +: 4] - 4'd1;
          w_borrow = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_load_fix = '0;
    w_load_bad = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (load_val[4*k +: 4] > BCD_MAX) begin
        w_load_bad = 1'b1;
      end else begin
        w_load_fix[4*k +: 4] = load_val[4*k +: 4];
      end
    end
  end

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    w_blank    = '0;
    w_zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run && (r_count[4*k +: 4] == 4'd0);
      w_blank[k] = (BLANK_LZ != 0) && (k != 0) && w_zero_run;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    seg7_bcd_digit u_digit (
      .i_bcd   (r_count[4*g +: 4]),
      .i_blank (w_blank[g]),
      .o_seg   (w_hex[SEG_W*g +: SEG_W])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc    <= '0;
      r_count    <= '0;
      r_hex      <= HexRst;
      r_tc       <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_presc    <= w_presc_d;
      r_hex      <= w_hex;
      r_tc       <= 1'b0;
      r_load_err <= 1'b0;
      if (clear) begin
        r_count <= '0;
      end else if (load) begin
        r_count    <= w_load_fix;
        r_load_err <= w_load_bad;
      end else if (w_tick) begin
        r_count <= up_dn ? w_cnt_up : w_cnt_dn;
        r_tc    <= up_dn ? w_carry : w_borrow;
      end
    end
  end

  assign count    = r_count;
  assign hex      = r_hex;
  assign tc       = r_tc;
  assign load_err = r_load_err;

endmodule

// File: doc/bcd_counter_display.md
Name: bcd_counter_display

Overview:
- Parametrised N-digit BCD up/down counter with a built-in prescaler and registered 7-segment decode for every digit.
- Generalises the single-digit combinational BCD-to-7-segment decoder. Adds multi-digit count state, load/clear, terminal-count pulse, invalid-load detection and optional leading-zero blanking.
- Sits between board switches/keys and the HEX display bank in lab top-levels.

Parameters:
- NUM_DIGITS, 4, number of BCD digits and HEX displays driven (1..8).
- PRESCALE, 1, clk cycles per count tick (1 = count every enabled cycle; legal range 1..2^26).
- BLANK_LZ, 0, 1 = blank leading zero digits; digit 0 is always shown.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable; the prescaler advances only while en=1.
- up_dn  input  1  1 = count up, 0 = count down; sampled on each tick.
- clear  input  1  synchronous clear of count and prescaler.
- load  input  1  synchronous parallel load from load_val.
- load_val  input  4*NUM_DIGITS  BCD load value; digit k is bits [4k+3:4k].
- count  output  4*NUM_DIGITS  current BCD count, registered.
- hex  output  7*NUM_DIGITS  segments; display k is bits [7k+6:7k]; bit 7k+6 = a ... bit 7k = g; active-low (0 = lit).
- tc  output  1  one-cycle pulse on wrap.
- load_err  output  1  one-cycle pulse when a loaded digit was >9.

Behaviour:
- Reset (async, active-high) sets these values:
  - count = 0, prescaler = 0, tc = 0, load_err = 0.
  - hex digit 0 = 0000001 ("0").
  - other digits = 0000001 if BLANK_LZ=0, else 1111111.
- Priority per cycle: reset > clear > load > tick.
- clear: count <= 0; prescaler <= 0; no tc.
- load:
  - Each digit <= load_val digit if <=9, else 0.
  - load_err=1 in the next cycle if any digit was >9.
  - Prescaler <= 0; no tc.
- Prescaler:
  - While en=1 and no clear/load, it increments.
  - At PRESCALE-1 it returns to 0 and a tick is issued that cycle.
  - en=0 holds the prescaler value (no restart).
  - PRESCALE=1 means a tick every enabled cycle.
- Tick, up:
  - Digit 0 increments; a digit at 9 goes to 0 and carries into the next digit (ripple within one cycle).
  - All-9s goes to all-0s with tc=1 for one cycle, registered with the new count.
- Tick, down:
  - Digit 0 decrements; a digit at 0 goes to 9 and borrows from the next digit.
  - All-0s goes to all-9s with tc=1.
- up_dn change takes effect on the next tick; no glitch in count.
- count updates on the edge where the tick or load is taken. hex reflects the new count one clk later (decode is registered, latency 1). tc and load_err align with the count update.
- Decode per digit:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100.
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100.
  - Any other code = 1111111 (unreachable internally; retained for safety).
- Leading-zero blanking (BLANK_LZ=1): digit k>0 is blanked iff it and all higher digits are 0. Digit 0 is never blanked.
- Reset asserted mid-count or mid-prescale forces the reset values immediately. The first tick after release needs a full PRESCALE cycles of en=1.
- NUM_DIGITS=1: the counter wraps at 9/0 and tc fires on every wrap.

Decomposition:
- Shared package seg7_pkg:
  - Constants SEG_0..SEG_9 and SEG_BLANK.
  - Constants BCD_MAX=4'd9 and SEG_W=7.
- One combinational sub-module seg7_bcd_digit: 4-bit BCD in, blank in, 7-bit active-low segments out. It is instantiated NUM_DIGITS times in a generate loop.
- The counter, prescaler and output registers live in the top module.

Test Plan:
- Reset then release, NUM_DIGITS=4, BLANK_LZ=0, PRESCALE=1, en=1, up_dn=1: after 10 cycles count=0x0010; hex digit0=0000001, digit1=1001111 (one cycle after the count).
- load with load_val=0x9999, then one tick up: count=0x0000, tc=1 for exactly one cycle. Down from 0x0000: count=0x9999, tc=1.
- load with load_val=0x12F4: count=0x1204, load_err=1 for one cycle, no tc.
- PRESCALE=5, en toggled low for 3 cycles after 2 enabled cycles: the first tick occurs after 5 enabled cycles total; count only changes on ticks.
- BLANK_LZ=1, count=0x0105: hex digit3=1111111, digit2=1001111, digit1=0000001, digit0=0100100. At count=0x0000 only digit0 shows 0000001.
- clear and load asserted together during a tick, then reset pulsed mid-prescale: clear wins (count=0); the async reset immediately restores the reset values on all outputs.
